reflet_int_responder: RTL

CPU-side endpoint of the 4-line interrupt bus driven by the external interrupt controller. Samples `int_in[3:0]`, applies a software mask and fixed priority, and presents one request at a time to the Reflet core over a req/ack handshake. Tracks nested in-service levels until the core signals return-from-interrupt. Memory-mapped control sits on the 8-bit system bus next to the external interrupt controller.

---
 rtl/reflet_int_pkg.sv | 21 ++
 rtl/reflet_int_prio_enc.sv | 25 ++
 rtl/reflet_int_responder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/reflet_int_pkg.sv
// Shared constants, register offsets and FSM state type for the Reflet
// interrupt responder.
package reflet_int_pkg;

  localparam int NUM_INT = 4;

  localparam logic INT_REG_CTRL = 1'b0;
  localparam logic INT_REG_STAT = 1'b1;

  localparam int GIE_BIT = 7;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } int_state_t;

  function automatic logic [NUM_INT-1:0] level_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/reflet_int_prio_enc.sv
// Lowest-set-bit encoder: index of the highest-priority (lowest-numbered)
// set bit plus a flag saying whether any bit is set.
module reflet_int_prio_enc
  import reflet_int_pkg::*;
(
  input  logic [NUM_INT-1:0] vec_i,
  output logic [1:0]         idx_o,
  output logic               valid_o
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = 2'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reflet_int_responder.sv
// CPU-side interrupt endpoint: masks and prioritises int_in, issues one
// req/ack request at a time and tracks in-service levels until return.
// Optional feature macro: REFLET_INT_NESTING_EN (nested preemption).
module reflet_int_responder
  import reflet_int_pkg::*;
#(
  parameter int                        base_addr_size = 16,
  parameter logic [base_addr_size-1:0] base_addr      = 16'hFF07
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic                      write_en,
  input  logic [7:0]                data_in,
  output logic [7:0]                data_out,
  input  logic [NUM_INT-1:0]        int_in,
  output logic                      int_req,
  output logic [1:0]                int_num,
  input  logic                      int_ack,
  input  logic                      int_ret,
  output logic                      in_service
);

  int_state_t          state_q, state_d;
  logic [1:0]          num_q, num_d;
  logic [NUM_INT-1:0]  mask_q, mask_d;
  logic                gie_q, gie_d;
  logic [NUM_INT-1:0]  active_q, active_d;
  logic                in_service_q;

  logic [base_addr_size-1:0] offset;
  logic                      sel;
  logic                      reg_off;
  logic [NUM_INT-1:0]        pending;
  logic [NUM_INT-1:0]        eligible;
  logic [1:0]                cur_idx, cand_idx;
  logic                      cur_vld, cand_vld;
  logic [2:0]                cur;
  logic                      ack_take;
  logic                      unused_data;

  // Block decodes two bytes: base_addr and base_addr+1.
  assign offset  = addr - base_addr;
  assign sel     = enable && (addr >= base_addr) && (offset[base_addr_size-1:1] == '0);
  assign reg_off = offset[0];
  assign pending = int_in & mask_q;
  assign unused_data = ^data_in[6:4];

  reflet_int_prio_enc u_cur_enc (
    .vec_i   (active_q),
    .idx_o   (cur_idx),
    .valid_o (cur_vld)
  );

`ifdef REFLET_INT_NESTING_EN
  assign cur = cur_vld ? {1'b0, cur_idx} : 3'd4;
`else
  // Any level in service blocks every new request.
  logic unused_cur;
  assign unused_cur = ^cur_idx;
  assign cur = cur_vld ? 3'd0 : 3'd4;
`endif

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_INT; i++) begin
      eligible[i] = gie_q && pending[i] && (3'(i) < cur);
    end
  end

  reflet_int_prio_enc u_cand_enc (
    .vec_i   (eligible),
    .idx_o   (cand_idx),
    .valid_o (cand_vld)
  );

  always_comb begin
    mask_d = mask_q;
    gie_d  = gie_q;
    if (sel && write_en && (reg_off == INT_REG_CTRL)) begin
      mask_d = data_in[NUM_INT-1:0];
      gie_d  = data_in[GIE_BIT];
    end
  end

  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    ack_take = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cand_vld) begin
          state_d = REQ;
          num_d   = cand_idx;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_d  = IDLE;
          ack_take = 1'b1;
        end else if (!(int_in[num_q] && mask_q[num_q] && gie_q)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Return clears first, then a same-cycle ack sets its level.
  always_comb begin
    active_d = active_q;
    if (int_ret) begin
`ifdef REFLET_INT_NESTING_EN
      if (cur_vld) active_d[cur_idx] = 1'b0;
`else
      active_d = '0;
`endif
    end
    if (ack_take) active_d = active_d | level_onehot(num_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      num_q        <= '0;
      mask_q       <= '0;
      gie_q        <= 1'b0;
      active_q     <= '0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      mask_q       <= mask_d;
      gie_q        <= gie_d;
      active_q     <= active_d;
      in_service_q <= |active_d;
    end
  end

  assign int_req    = (state_q == REQ);
  assign int_num    = num_q;
  assign in_service = in_service_q;

  always_comb begin
    data_out = '0;
    if (sel) begin
      if (reg_off == INT_REG_STAT) data_out = {pending, active_q};
      else                         data_out = {gie_q, 3'b000, mask_q};
    end
  end

endmodule
